// File: rtl/regfile_sb.sv
// regfile_sb: 2-read/1-write register file with write-to-read bypass, optional
// hard-wired zero register and a per-register pending-write scoreboard.
module regfile_sb #(
   parameter int unsigned DATA_W   = 32,
   parameter int unsigned ADDR_W   = 5,
   parameter int unsigned ZERO_REG = 1,
   parameter int unsigned BYPASS   = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [ADDR_W-1:0] rs_add,
   input  logic [ADDR_W-1:0] rt_add,
   output logic [DATA_W-1:0] rs_out,
   output logic [DATA_W-1:0] rt_out,
   output logic              rs_busy,
   output logic              rt_busy,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_add,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              iss_en,
   input  logic [ADDR_W-1:0] iss_add,
   output logic [ADDR_W:0]   pend_cnt,
   input  logic [ADDR_W-1:0] dbg_sel,
   output logic [DATA_W-1:0] dbg_data
);

   localparam int unsigned DEPTH = 1 << ADDR_W;
   localparam logic [ADDR_W:0] CNT_ONE = {{ADDR_W{1'b0}}, 1'b1};

   logic [DATA_W-1:0] regs_q [DEPTH];
   logic [DEPTH-1:0]  busy_q;
   logic [DEPTH-1:0]  busy_d;
   logic [ADDR_W:0]   pend_q;
   logic [ADDR_W:0]   pend_d;

   logic wr_ok;
   logic iss_ok;
   logic set_new;
   logic clr_old;
   logic rs_fwd;
   logic rt_fwd;
   logic rs_zero;
   logic rt_zero;

   // Qualify strobes: with ZERO_REG, anything aimed at r0 is dropped.
   always_comb begin
      wr_ok   = wr_en  && !((ZERO_REG != 0) && (wr_add  == '0));
      iss_ok  = iss_en && !((ZERO_REG != 0) && (iss_add == '0));
      rs_zero = (ZERO_REG != 0) && (rs_add == '0);
      rt_zero = (ZERO_REG != 0) && (rt_add == '0);
      rs_fwd  = (BYPASS != 0) && wr_ok && (wr_add == rs_add);
      rt_fwd  = (BYPASS != 0) && wr_ok && (wr_add == rt_add);
   end

   // Read ports: zero register first, then bypass, then stored contents.
   always_comb begin
      rs_out   = rs_zero ? '0 : (rs_fwd ? wr_data : regs_q[rs_add]);
      rt_out   = rt_zero ? '0 : (rt_fwd ? wr_data : regs_q[rt_add]);
      rs_busy  = busy_q[rs_add] & ~rs_fwd;
      rt_busy  = busy_q[rt_add] & ~rt_fwd;
      dbg_data = regs_q[dbg_sel];
      pend_cnt = pend_q;
   end

   // Register array write; reset clears every entry.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            regs_q[i] <= '0;
         end
      end else if (wr_ok) begin
         regs_q[wr_add] <= wr_data;
      end
   end

   // Scoreboard next state: the issue set is applied last so it beats a clear.
   always_comb begin
      busy_d = busy_q;
      if (wr_ok) begin
         busy_d[wr_add] = 1'b0;
      end
      if (iss_ok) begin
         busy_d[iss_add] = 1'b1;
      end
   end

   // Pending counter tracks popcount(busy) incrementally: +1 for a fresh set,
   // -1 for clearing a busy bit that is not simultaneously re-issued.
   always_comb begin
      set_new = iss_ok && !busy_q[iss_add];
      clr_old = wr_ok && busy_q[wr_add] && !(iss_ok && (iss_add == wr_add));
      pend_d  = pend_q;
      if (set_new && !clr_old) begin
         pend_d = pend_q + CNT_ONE;
      end else if (clr_old && !set_new) begin
         pend_d = pend_q - CNT_ONE;
      end
   end

   // Scoreboard and pending-count state.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         busy_q <= '0;
         pend_q <= '0;
      end else begin
         busy_q <= busy_d;
         pend_q <= pend_d;
      end
   end

endmodule

// File: tb/tb_regfile_sb.sv
// Directed self-checking bench for regfile_sb. A second instance with
// BYPASS=0 shares the stimulus to show the non-forwarding behaviour.
module tb_regfile_sb;

   logic        clk;
   logic        rst;
   logic [4:0]  rs_add;
   logic [4:0]  rt_add;
   logic        wr_en;
   logic [4:0]  wr_add;
   logic [31:0] wr_data;
   logic        iss_en;
   logic [4:0]  iss_add;
   logic [4:0]  dbg_sel;

   logic [31:0] rs_out, rt_out, dbg_data;
   logic        rs_busy, rt_busy;
   logic [5:0]  pend_cnt;

   logic [31:0] nb_rs_out, nb_rt_out, nb_dbg_data;
   logic        nb_rs_busy, nb_rt_busy;
   logic [5:0]  nb_pend_cnt;

   int n_vec = 0;
   int n_err = 0;

   regfile_sb #(
      .DATA_W  (32),
      .ADDR_W  (5),
      .ZERO_REG(1),
      .BYPASS  (1)
   ) u_dut (
      .clk     (clk),
      .rst     (rst),
      .rs_add  (rs_add),
      .rt_add  (rt_add),
      .rs_out  (rs_out),
      .rt_out  (rt_out),
      .rs_busy (rs_busy),
      .rt_busy (rt_busy),
      .wr_en   (wr_en),
      .wr_add  (wr_add),
      .wr_data (wr_data),
      .iss_en  (iss_en),
      .iss_add (iss_add),
      .pend_cnt(pend_cnt),
      .dbg_sel (dbg_sel),
      .dbg_data(dbg_data)
   );

   regfile_sb #(
      .DATA_W  (32),
      .ADDR_W  (5),
      .ZERO_REG(1),
      .BYPASS  (0)
   ) u_nobyp (
      .clk     (clk),
      .rst     (rst),
      .rs_add  (rs_add),
      .rt_add  (rt_add),
      .rs_out  (nb_rs_out),
      .rt_out  (nb_rt_out),
      .rs_busy (nb_rs_busy),
      .rt_busy (nb_rt_busy),
      .wr_en   (wr_en),
      .wr_add  (wr_add),
      .wr_data (wr_data),
      .iss_en  (iss_en),
      .iss_add (iss_add),
      .pend_cnt(nb_pend_cnt),
      .dbg_sel (dbg_sel),
      .dbg_data(nb_dbg_data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // Advance to just after the next rising edge.
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst     = 1'b0;
      rs_add  = '0;
      rt_add  = '0;
      wr_en   = 1'b0;
      wr_add  = '0;
      wr_data = '0;
      iss_en  = 1'b0;
      iss_add = '0;
      dbg_sel = '0;

      // Reset state
      #12;
      rs_add = 5'd7; rt_add = 5'd9; dbg_sel = 5'd7;
      #1;
      check_eq("rst_rs_out", rs_out, 32'h0);
      check_eq("rst_rt_out", rt_out, 32'h0);
      check_eq("rst_dbg", dbg_data, 32'h0);
      check_eq("rst_pend", {26'h0, pend_cnt}, 32'd0);
      check_eq("rst_busy", {30'h0, rs_busy, rt_busy}, 32'd0);
      rst = 1'b1;
      cyc();

      // Write then read r7
      wr_en = 1'b1; wr_add = 5'd7; wr_data = 32'hDEADBEEF;
      cyc();
      wr_en = 1'b0; rs_add = 5'd7; dbg_sel = 5'd7;
      #1;
      check_eq("r7_rs_out", rs_out, 32'hDEADBEEF);
      check_eq("r7_dbg", dbg_data, 32'hDEADBEEF);
      check_eq("r7_nb_rs_out", nb_rs_out, 32'hDEADBEEF);

      // Write to r0 is discarded
      wr_en = 1'b1; wr_add = 5'd0; wr_data = 32'h1234;
      #1;
      rs_add = 5'd0;
      #1;
      check_eq("r0_bypass_blocked", rs_out, 32'h0);
      cyc();
      wr_en = 1'b0; dbg_sel = 5'd0;
      #1;
      check_eq("r0_rs_out", rs_out, 32'h0);
      check_eq("r0_dbg", dbg_data, 32'h0);

      // Bypass: preload r9, then same-cycle write of r9
      wr_en = 1'b1; wr_add = 5'd9; wr_data = 32'h11;
      cyc();
      wr_data = 32'h55; rs_add = 5'd9; rt_add = 5'd9; dbg_sel = 5'd9;
      #1;
      check_eq("byp_rs_out", rs_out, 32'h55);
      check_eq("byp_rt_out", rt_out, 32'h55);
      check_eq("byp_dbg_old", dbg_data, 32'h11);
      check_eq("nobyp_rs_old", nb_rs_out, 32'h11);
      check_eq("nobyp_rt_old", nb_rt_out, 32'h11);
      cyc();
      wr_en = 1'b0;
      #1;
      check_eq("byp_dbg_new", dbg_data, 32'h55);

      // Scoreboard: issue r3
      iss_en = 1'b1; iss_add = 5'd3; rs_add = 5'd3;
      #1;
      check_eq("iss_not_yet_busy", {31'h0, rs_busy}, 32'd0);
      cyc();
      iss_en = 1'b0;
      #1;
      check_eq("iss_r3_busy", {31'h0, rs_busy}, 32'd1);
      check_eq("iss_r3_pend", {26'h0, pend_cnt}, 32'd1);
      wr_en = 1'b1; wr_add = 5'd3; wr_data = 32'h33;
      #1;
      check_eq("wb_r3_busy_masked", {31'h0, rs_busy}, 32'd0);
      check_eq("wb_r3_nb_busy", {31'h0, nb_rs_busy}, 32'd1);
      check_eq("wb_r3_pend_before", {26'h0, pend_cnt}, 32'd1);
      cyc();
      wr_en = 1'b0;
      #1;
      check_eq("wb_r3_pend_after", {26'h0, pend_cnt}, 32'd0);
      check_eq("wb_r3_busy_after", {31'h0, rs_busy}, 32'd0);

      // Simultaneous issue and write of busy r4
      iss_en = 1'b1; iss_add = 5'd4;
      cyc();
      wr_en = 1'b1; wr_add = 5'd4; wr_data = 32'h44;
      cyc();
      iss_en = 1'b0; wr_en = 1'b0; rs_add = 5'd4; dbg_sel = 5'd4;
      #1;
      check_eq("sim_r4_busy", {31'h0, rs_busy}, 32'd1);
      check_eq("sim_r4_pend", {26'h0, pend_cnt}, 32'd1);
      check_eq("sim_r4_data", dbg_data, 32'h44);

      // WAW: re-issue busy r4, pend unchanged
      iss_en = 1'b1; iss_add = 5'd4;
      cyc();
      iss_en = 1'b0;
      #1;
      check_eq("waw_pend", {26'h0, pend_cnt}, 32'd1);
      wr_en = 1'b1; wr_add = 5'd4; wr_data = 32'h45;
      cyc();
      wr_en = 1'b0;
      #1;
      check_eq("r4_clear_pend", {26'h0, pend_cnt}, 32'd0);

      // Write to a non-busy register leaves pend alone
      wr_en = 1'b1; wr_add = 5'd5; wr_data = 32'h5;
      cyc();
      wr_en = 1'b0;
      #1;
      check_eq("nonbusy_wr_pend", {26'h0, pend_cnt}, 32'd0);

      // Issue r0 is ignored
      iss_en = 1'b1; iss_add = 5'd0;
      cyc();
      iss_en = 1'b0; rs_add = 5'd0;
      #1;
      check_eq("iss_r0_pend", {26'h0, pend_cnt}, 32'd0);
      check_eq("iss_r0_busy", {31'h0, rs_busy}, 32'd0);

      // Fill all 31 non-zero registers
      for (int i = 1; i < 32; i++) begin
         iss_en = 1'b1; iss_add = 5'(i);
         cyc();
      end
      iss_en = 1'b0;
      #1;
      check_eq("fill_pend", {26'h0, pend_cnt}, 32'd31);
      rs_add = 5'd17; rt_add = 5'd31;
      #1;
      check_eq("fill_busy", {30'h0, rs_busy, rt_busy}, 32'd3);

      // Drain in reverse order
      for (int i = 31; i >= 1; i--) begin
         wr_en = 1'b1; wr_add = 5'(i); wr_data = 32'h100 + 32'(i);
         cyc();
         check_eq("drain_pend", {26'h0, pend_cnt}, 32'(i - 1));
      end
      wr_en = 1'b0;
      #1;
      check_eq("drain_final", {26'h0, pend_cnt}, 32'd0);

      // Asynchronous reset mid-run with registers loaded and some busy
      iss_en = 1'b1; iss_add = 5'd12;
      cyc();
      iss_en = 1'b0;
      rs_add = 5'd12; rt_add = 5'd7; dbg_sel = 5'd20;
      #1;
      check_eq("pre_rst_pend", {26'h0, pend_cnt}, 32'd1);
      check_eq("pre_rst_dbg", dbg_data, 32'h114);
      #1;
      rst = 1'b0;
      #1;
      check_eq("mid_rst_rs_out", rs_out, 32'h0);
      check_eq("mid_rst_rt_out", rt_out, 32'h0);
      check_eq("mid_rst_dbg", dbg_data, 32'h0);
      check_eq("mid_rst_pend", {26'h0, pend_cnt}, 32'd0);
      check_eq("mid_rst_busy", {30'h0, rs_busy, rt_busy}, 32'd0);
      #1;
      rst = 1'b1;
      wr_en = 1'b1; wr_add = 5'd7; wr_data = 32'hAB;
      cyc();
      wr_en = 1'b0; dbg_sel = 5'd7;
      #1;
      check_eq("post_rst_wr", dbg_data, 32'hAB);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
